// File: rtl/tail_light_pkg.sv
// ---------------------------------------------------------------------------
// tail_light_pkg
// Shared definitions for the tail-light lamp controller and its monitor.
//   - Lamp pattern constants. Lamps are active-low: a 0 bit is a lit lamp.
//   - Dir codes reported by the monitor.
//   - Monitor state enum, with helpers that decode Dir and Lock from a state.
// ---------------------------------------------------------------------------
package tail_light_pkg;

    // Lamp word patterns, bit order {A,B,F,G}, active-low
    localparam logic [3:0] PAT_OFF    = 4'b1111;  // all lamps dark
    localparam logic [3:0] PAT_R1     = 4'b0111;  // first lamp of either sweep
    localparam logic [3:0] PAT_R2     = 4'b0011;
    localparam logic [3:0] PAT_R3     = 4'b0001;
    localparam logic [3:0] PAT_R4     = 4'b0000;
    localparam logic [3:0] PAT_L2     = 4'b0101;
    localparam logic [3:0] PAT_L3     = 4'b0100;
    localparam logic [3:0] PAT_ALL_ON = 4'b0000;  // every lamp lit

    // Decoded mode codes
    localparam logic [1:0] DIR_NONE   = 2'b00;
    localparam logic [1:0] DIR_RIGHT  = 2'b01;
    localparam logic [1:0] DIR_LEFT   = 2'b10;
    localparam logic [1:0] DIR_HAZARD = 2'b11;

    // Each sweep state is named for the step it waits in; the pattern that
    // moves it on is the next one in the sweep.
    typedef enum logic [3:0] {
        ST_OFF   = 4'd0,
        ST_PEND  = 4'd1,
        ST_R1    = 4'd2,
        ST_R2    = 4'd3,
        ST_R3    = 4'd4,
        ST_R4    = 4'd5,
        ST_L1    = 4'd6,
        ST_L2    = 4'd7,
        ST_L3    = 4'd8,
        ST_L4    = 4'd9,
        ST_H_ON  = 4'd10,
        ST_H_OFF = 4'd11,
        ST_ERR   = 4'd12
    } mon_state_e;

    function automatic logic [1:0] dir_of(input mon_state_e s);
        logic [1:0] d;
        case (s)
            ST_R1, ST_R2, ST_R3, ST_R4: d = DIR_RIGHT;
            ST_L1, ST_L2, ST_L3, ST_L4: d = DIR_LEFT;
            ST_H_ON, ST_H_OFF:          d = DIR_HAZARD;
            default:                    d = DIR_NONE;
        endcase
        return d;
    endfunction

    // Lock is low only while the mode is still ambiguous or after an error
    function automatic logic lock_of(input mon_state_e s);
        return !((s == ST_PEND) || (s == ST_ERR));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up counter that sticks at its all-ones value.
// Ports:
//   clk_i   clock, rising edge
//   srst_i  synchronous active-high reset, clears the count
//   clr_i   synchronous clear, wins over inc_i
//   inc_i   add one unless already saturated
//   cnt_o   current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         srst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tail_light_monitor.sv
// ---------------------------------------------------------------------------
// tail_light_monitor
// Watches the lamp word of the tail-light controller, recovers the active
// mode, flags illegal pattern steps and counts completed sweeps.
// Ports:
//   Clk     clock, rising edge
//   Res     synchronous active-high reset (dominates Vld)
//   Vld     sample strobe; C is evaluated only when high
//   C       lamp word {A,B,F,G}, active-low
//   Dir     mode: 00 off, 01 right, 10 left, 11 hazard
//   Lock    mode known and sequence legal
//   Err     one-cycle pulse on an illegal step
//   Wrap    one-cycle pulse on completing a sweep / flash period
//   CycCnt  saturating count of completed sweeps in the current mode
//   ErrCnt  saturating count of illegal steps (only with TAIL_MON_ERRCNT_EN)
// Build option: define TAIL_MON_ERRCNT_EN to add the ErrCnt port and counter.
// All outputs are registered.
// ---------------------------------------------------------------------------
module tail_light_monitor
    import tail_light_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Res,
    input  logic             Vld,
    input  logic [3:0]       C,
    output logic [1:0]       Dir,
    output logic             Lock,
    output logic             Err,
    output logic             Wrap,
    output logic [CNT_W-1:0] CycCnt
`ifdef TAIL_MON_ERRCNT_EN
    ,
    output logic [7:0]       ErrCnt
`endif
);

    mon_state_e state_q, state_d;
    logic [1:0] dir_q;
    logic       lock_q;
    logic       err_q, err_d;
    logic       wrap_q, wrap_d;
    logic       cyc_clr;

    // Next-state decode. Anything not listed as a legal step lands in ERR;
    // because every legal step changes the pattern, repeating a pattern is
    // caught by the same default (1111 in OFF and the 1111 abort excepted).
    always_comb begin
        mon_state_e nxt;
        state_d = state_q;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        nxt     = ST_ERR;
        if (Vld) begin
            if (state_q == ST_ERR) begin
                // Sticky until the controller goes dark; no repeated Err
                state_d = (C == PAT_OFF) ? ST_OFF : ST_ERR;
            end else if ((C == PAT_OFF) && (state_q != ST_H_OFF)) begin
                // Controller went dark mid-sequence: a restart, not an error
                state_d = ST_OFF;
            end else begin
                case (state_q)
                    ST_OFF: begin
                        if (C == PAT_R1)          nxt = ST_PEND;
                        else if (C == PAT_ALL_ON) nxt = ST_H_OFF;
                    end
                    // 0111 opens both sweeps; the second step tells them apart
                    ST_PEND: begin
                        if (C == PAT_R2)      nxt = ST_R2;
                        else if (C == PAT_L2) nxt = ST_L2;
                    end
                    ST_R1:    if (C == PAT_R2)     nxt = ST_R2;
                    ST_R2:    if (C == PAT_R3)     nxt = ST_R3;
                    ST_R3:    if (C == PAT_R4)     nxt = ST_R4;
                    ST_R4:    if (C == PAT_R1)     nxt = ST_R1;
                    ST_L1:    if (C == PAT_L2)     nxt = ST_L2;
                    ST_L2:    if (C == PAT_L3)     nxt = ST_L3;
                    ST_L3:    if (C == PAT_ALL_ON) nxt = ST_L4;
                    ST_L4:    if (C == PAT_R1)     nxt = ST_L1;
                    ST_H_OFF: if (C == PAT_OFF)    nxt = ST_H_ON;
                    ST_H_ON:  if (C == PAT_ALL_ON) nxt = ST_H_OFF;
                    default:  nxt = ST_ERR;
                endcase
                state_d = nxt;
                err_d   = (nxt == ST_ERR);
                // R4, L4 and H_ON are each reachable only by completing a
                // period, so entering them marks a wrap
                wrap_d  = (nxt == ST_R4) || (nxt == ST_L4) || (nxt == ST_H_ON);
            end
        end
    end

    // Counting restarts whenever the monitor falls back to OFF or ERR
    assign cyc_clr = Vld && ((state_d == ST_OFF) || (state_d == ST_ERR));

    always_ff @(posedge Clk) begin
        if (Res) begin
            state_q <= ST_OFF;
            dir_q   <= DIR_NONE;
            lock_q  <= 1'b1;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_of(state_d);
            lock_q  <= lock_of(state_d);
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    sat_counter #(
        .W      (CNT_W)
    ) u_cyc_cnt (
        .clk_i  (Clk),
        .srst_i (Res),
        .clr_i  (cyc_clr),
        .inc_i  (wrap_d),
        .cnt_o  (CycCnt)
    );

`ifdef TAIL_MON_ERRCNT_EN
    // Only reset clears the error tally; it survives mode changes
    sat_counter #(
        .W      (8)
    ) u_err_cnt (
        .clk_i  (Clk),
        .srst_i (Res),
        .clr_i  (1'b0),
        .inc_i  (err_d),
        .cnt_o  (ErrCnt)
    );
`endif

    assign Dir  = dir_q;
    assign Lock = lock_q;
    assign Err  = err_q;
    assign Wrap = wrap_q;

endmodule
